// File: rtl/ml_pkg.sv
// Shared types and constants for the ML accelerator pipeline.
// Imported by the pooling stage and its helpers.
package ml_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    B1   = 2'd1,
    B2   = 2'd2,
    B3   = 2'd3
  } pool_state_t;

  localparam int L0_POOL_ENTRIES = 169;
  localparam int L0_DATA_WIDTH   = 18;

endpackage

// File: rtl/ram.sv
// Simple dual-port RAM: one write port, one registered read port.
// A read of the address being written returns the previous contents.
module ram #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 18
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [ADDR_WIDTH-1:0] raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [2**ADDR_WIDTH];
  logic [DATA_WIDTH-1:0] rdata_q;

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/l0_maxpool.sv
// 2x2 max-pooling stage for layer 0: reduces 4-beat windows per channel
// and stores the pooled map in two RAMs read back by the next layer.
module l0_maxpool
  import ml_pkg::*;
#(
  parameter int DATA_WIDTH = L0_DATA_WIDTH,
  parameter int MAP_DIM    = 13,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  tx_done,
  input  logic                  vld_in,
  input  logic [DATA_WIDTH-1:0] din_0,
  input  logic [DATA_WIDTH-1:0] din_1,
  input  logic [ADDR_WIDTH-1:0] addr_rd,
  output logic [DATA_WIDTH-1:0] dout_0,
  output logic [DATA_WIDTH-1:0] dout_1,
  output logic                  rdy,
  output logic                  done,
  output logic                  err
);

  localparam int ENTRIES = MAP_DIM * MAP_DIM;

  pool_state_t           state_q;
  logic [DATA_WIDTH-1:0] max0_q, max1_q;
  logic [DATA_WIDTH-1:0] max0_d, max1_d;
  logic [ADDR_WIDTH-1:0] addr_wr_q;
  logic                  err_q;
  logic                  clr;
  logic                  full;
  logic                  we;

  assign clr    = rst | tx_done;
  assign full   = (addr_wr_q == ADDR_WIDTH'(ENTRIES));
  assign max0_d = (din_0 > max0_q) ? din_0 : max0_q;
  assign max1_d = (din_1 > max1_q) ? din_1 : max1_q;
  // A clear in the final beat cycle suppresses the write.
  assign we     = !clr && (state_q == B3) && vld_in;

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q   <= IDLE;
      max0_q    <= '0;
      max1_q    <= '0;
      addr_wr_q <= '0;
      err_q     <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (vld_in && !full) begin
            max0_q  <= din_0;
            max1_q  <= din_1;
            state_q <= B1;
          end
        end
        B1, B2: begin
          if (vld_in) begin
            max0_q  <= max0_d;
            max1_q  <= max1_d;
            state_q <= (state_q == B1) ? B2 : B3;
          end else begin
            err_q   <= 1'b1;
            state_q <= IDLE;
          end
        end
        B3: begin
          if (vld_in) begin
            addr_wr_q <= addr_wr_q + 1'b1;
          end else begin
            err_q <= 1'b1;
          end
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  ram #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) pool_ram_0 (
    .clk     (clk),
    .rst     (rst),
    .we_i    (we),
    .waddr_i (addr_wr_q),
    .wdata_i (max0_d),
    .raddr_i (addr_rd),
    .rdata_o (dout_0)
  );

  ram #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) pool_ram_1 (
    .clk     (clk),
    .rst     (rst),
    .we_i    (we),
    .waddr_i (addr_wr_q),
    .wdata_i (max1_d),
    .raddr_i (addr_rd),
    .rdata_o (dout_1)
  );

  assign rdy  = (addr_rd < addr_wr_q);
  assign done = full;
  assign err  = err_q;

endmodule

// File: tb/tb_l0_maxpool.sv
// Directed bench for l0_maxpool with hand-computed expectations.
module tb_l0_maxpool;

  logic        clk = 1'b0;
  logic        rst;
  logic        tx_done;
  logic        vld_in;
  logic [17:0] din_0, din_1;
  logic [7:0]  addr_rd;
  logic [17:0] dout_0, dout_1;
  logic        rdy, done, err;

  int n_chk = 0;
  int n_err = 0;

  l0_maxpool dut (
    .clk     (clk),
    .rst     (rst),
    .tx_done (tx_done),
    .vld_in  (vld_in),
    .din_0   (din_0),
    .din_1   (din_1),
    .addr_rd (addr_rd),
    .dout_0  (dout_0),
    .dout_1  (dout_1),
    .rdy     (rdy),
    .done    (done),
    .err     (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic beat(input logic [17:0] a, input logic [17:0] b);
    vld_in = 1'b1;
    din_0  = a;
    din_1  = b;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    vld_in = 1'b0;
    din_0  = '0;
    din_1  = '0;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_rdy(input string tag, input logic [7:0] a,
                         input logic e);
    addr_rd = a;
    #1;
    chk(tag, {31'd0, rdy}, {31'd0, e});
  endtask

  task automatic rd(input logic [7:0] a, output logic [17:0] d0,
                    output logic [17:0] d1);
    vld_in  = 1'b0;
    addr_rd = a;
    @(posedge clk);
    #1;
    d0 = dout_0;
    d1 = dout_1;
  endtask

  logic [17:0] r0, r1;

  initial begin
    rst = 1'b1; tx_done = 1'b0; vld_in = 1'b0;
    din_0 = '0; din_1 = '0; addr_rd = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_dout0", dout_0, 0);
    chk("rst_dout1", dout_1, 0);
    chk("rst_rdy",   rdy, 0);
    chk("rst_done",  done, 0);
    chk("rst_err",   err, 0);

    // single window, rdy timing and read latency
    beat(18'd5, 0); beat(18'd9, 0); beat(18'd3, 0);
    vld_in = 1'b1; din_0 = 18'd7; din_1 = 0; addr_rd = 0;
    #1;
    chk("w1_rdy_before", rdy, 0);
    @(posedge clk);
    #1;
    vld_in = 1'b0;
    chk_rdy("w1_rdy_after", 8'd0, 1'b1);
    @(posedge clk);
    #1;
    chk("w1_dout0", dout_0, 9);
    chk("w1_dout1", dout_1, 0);

    // aborted window then full-width windows at the same address
    beat(18'd1, 18'd1); beat(18'd2, 18'd2);
    idle();
    chk("abort_err", err, 1);
    chk_rdy("abort_rdy1", 8'd1, 1'b0);
    chk_rdy("abort_rdy0", 8'd0, 1'b1);
    beat(18'h3FFFF, 18'h00000); beat(18'h00001, 18'h3FFFF);
    beat(18'h00002, 18'h00005); beat(18'h00003, 18'h3FFFE);
    beat(18'h00100, 0); beat(18'h00100, 0);
    beat(18'h00100, 0); beat(18'h00100, 18'h00200);
    idle();
    rd(8'd1, r0, r1);
    chk("wide_ch0", r0, 18'h3FFFF);
    chk("wide_ch1", r1, 18'h3FFFF);
    rd(8'd2, r0, r1);
    chk("equal_ch0", r0, 18'h00100);
    chk("equal_ch1", r1, 18'h00200);
    chk("err_sticky", err, 1);

    // tx_done on the final beat: no write, pointer cleared
    beat(18'h10, 18'h10); beat(18'h10, 18'h10); beat(18'h10, 18'h10);
    vld_in = 1'b1; din_0 = 18'h2AAAA; din_1 = 18'h2AAAA; tx_done = 1'b1;
    @(posedge clk);
    #1;
    tx_done = 1'b0; vld_in = 1'b0;
    chk("txd_err", err, 0);
    chk("txd_done", done, 0);
    chk_rdy("txd_rdy0", 8'd0, 1'b0);
    beat(18'h3FFFF, 18'h100); beat(18'h1, 18'h100);
    beat(18'h1, 18'h100); beat(18'h1, 18'h100);
    idle();
    chk_rdy("txd_rdy0_after", 8'd0, 1'b1);
    chk_rdy("txd_rdy1_after", 8'd1, 1'b0);
    rd(8'd0, r0, r1);
    chk("desc_ch0", r0, 18'h3FFFF);
    chk("desc_ch1", r1, 18'h00100);

    // reset while in B2
    beat(18'd1, 18'd1);
    idle();
    chk("pre_rst_err", err, 1);
    beat(18'd4, 18'd1); beat(18'd8, 18'd7);
    rst = 1'b1; vld_in = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("mrst_dout0", dout_0, 0);
    chk("mrst_dout1", dout_1, 0);
    chk("mrst_err",   err, 0);
    chk("mrst_done",  done, 0);
    chk_rdy("mrst_rdy", 8'd0, 1'b0);
    beat(18'd4, 18'd1); beat(18'd8, 18'd7);
    beat(18'd2, 18'd7); beat(18'd6, 18'd3);
    idle();
    chk_rdy("mrst_rdy1", 8'd1, 1'b0);
    rd(8'd0, r0, r1);
    chk("mrst_ch0", r0, 8);
    chk("mrst_ch1", r1, 7);

    // full map, back to back
    tx_done = 1'b1;
    idle();
    tx_done = 1'b0;
    addr_rd = 8'd168;
    for (int k = 0; k < 169; k++) begin
      if (k == 168) begin
        chk("done_early", done, 0);
        chk("rdy_last_early", rdy, 0);
      end
      beat(18'd0, 18'(168 - k));
      beat(18'd0, 18'd0);
      beat(18'(k), 18'd0);
      beat(18'd0, 18'd0);
    end
    chk("done_rise", done, 1);
    beat(18'h3FFFF, 18'h3FFFF); beat(18'h3FFFF, 18'h3FFFF);
    beat(18'h3FFFF, 18'h3FFFF); beat(18'h3FFFF, 18'h3FFFF);
    idle();
    chk("done_hold", done, 1);
    chk("full_err", err, 0);
    chk_rdy("full_rdy168", 8'd168, 1'b1);
    chk_rdy("full_rdy169", 8'd169, 1'b0);
    for (int k = 0; k < 169; k++) begin
      rd(8'(k), r0, r1);
      chk($sformatf("map_ch0[%0d]", k), r0, k);
      chk($sformatf("map_ch1[%0d]", k), r1, 168 - k);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/l0_maxpool.md
# l0_maxpool

Downstream consumer of the first convolution layer's feature-map buffer. It accepts the 2x2 pooling windows the layer streams out as four consecutive data beats per window, for both output channels in parallel. It reduces each window to its maximum and stores the 13x13 pooled map per channel in local RAM. The next layer reads the stored map through a read-address port gated by `rdy`.

## Interface
Parameters:
- `DATA_WIDTH`, 18: feature value width (unsigned, post-ReLU)
- `MAP_DIM`, 13: pooled map edge; map holds MAP_DIM*MAP_DIM = 169 entries
- `ADDR_WIDTH`, 8: pooled-map address width

Ports:
- `clk`  in  1  clock; all logic on rising edge
- `rst`  in  1  synchronous, active-high reset
- `tx_done`  in  1  frame finished; synchronous clear of pointers, state and flags (same effect as `rst` except RAM contents)
- `vld_in`  in  1  window beat valid; high for exactly 4 consecutive cycles per window
- `din_0`, `din_1`  in  DATA_WIDTH  channel 0/1 beat data, sampled when `vld_in`=1
- `addr_rd`  in  ADDR_WIDTH  read address from next layer
- `dout_0`, `dout_1`  out  DATA_WIDTH  pooled values at `addr_rd`, registered
- `rdy`  out  1  `addr_rd` < `addr_wr` (entry already written)
- `done`  out  1  all 169 entries written
- `err`  out  1  sticky: window aborted (`vld_in` dropped before beat 4)

## Operation
- FSM states: `IDLE`, `B1`, `B2`, `B3`.
  - IDLE: on `vld_in` load `max_0`<=`din_0`, `max_1`<=`din_1`, go to B1.
  - B1, B2: on `vld_in` update `max_n`<=max(`max_n`,`din_n`) and advance.
  - B3: on `vld_in` write max(`max_n`,`din_n`) to RAM n at `addr_wr`, increment `addr_wr`, return to IDLE.
  - B1–B3 with `vld_in`=0: discard window, set `err`, return to IDLE; `addr_wr` unchanged.
- Compare is unsigned, full DATA_WIDTH; ties keep the held value (result identical either way).
- `addr_wr` counts 0..169. `done` = (`addr_wr`==169). While `done`=1, `vld_in` is ignored: no writes, state stays IDLE, no wrap.
- `tx_done` or `rst`: `addr_wr`<=0, state<=IDLE, `max_n`<=0, `err`<=0. `tx_done` in the same cycle as a B3 beat wins: no write, no increment.
- RAMs have a write port (`addr_wr`) and a read port (`addr_rd`). Contents are not cleared by reset.
- Read of an address equal to the one being written in the same cycle returns the old data. The reader gates on `rdy`, so this is never consumed.

## Timing
- Reset values: `dout_0`=`dout_1`=0, `rdy`=0, `done`=0, `err`=0, state IDLE, `addr_wr`=0.
- Window latency: the write occurs on the edge ending beat 4. `rdy` for that address is high the following cycle.
- Back-to-back windows: beat 1 of the next window may arrive in the cycle right after beat 4, giving a sustained rate of one window per 4 cycles. Any number of idle cycles between windows is allowed.
- Read latency: `dout_n` is valid 1 cycle after `addr_rd` is presented.
- `rdy` is combinational from registered `addr_wr` and input `addr_rd`.
- `done` rises the cycle after the 169th write.

## Structure
- Shared package `ml_pkg`: `pool_state_t` enum (IDLE, B1, B2, B3), constant `L0_POOL_ENTRIES`=169, `L0_DATA_WIDTH`=18.
- Sub-module: the existing `ram` (ADDR_WIDTH=8, DATA_WIDTH=18), instantiated twice (`pool_ram_0`, `pool_ram_1`). FSM, max registers and pointer stay in `l0_maxpool`.

## Test plan
- Single window, ch0 beats 5, 9, 3, 7 and ch1 beats 0, 0, 0, 0 -> ch0 entry 0 = 9, ch1 entry 0 = 0; `rdy` with `addr_rd`=0 is high exactly 1 cycle after beat 4; `dout_0`=9 one cycle after the read.
- 169 back-to-back windows with ch0 = window index in beat 3 and 0 elsewhere -> entry k = k; `done` rises the cycle after window 169. A 170th window is ignored: `addr_wr` stays 169 and entry 0 is unchanged.
- `vld_in` dropped after beat 2 -> `err`=1, `addr_wr` unchanged. The next full window (max 0x3FFFF) is written at that same address, confirming the max-value width.
- `tx_done` asserted during a B3 beat -> no write, `addr_wr`=0, `err`=0. A following window is written at address 0.
- `rst` mid-window (state B2) -> IDLE, all outputs at reset values. A new window after reset is pooled correctly.
- Equal beats 0x00100 x4 and descending beats 0x3FFFF, 1, 1, 1 -> results 0x00100 and 0x3FFFF.
